ibex_data_resp: RTL and testbench

Word-addressed data-memory responder for the Ibex LSU data interface. It answers data-side requests with configurable grant delay, a bounded number of outstanding requests and an injectable access-fault region. Responses can be stalled by a test hook. It is the memory end of the `data_req/gnt/rvalid` protocol and is used in simulation top levels and small FPGA builds in place of a real bus.

---
 rtl/ibex_pkg.sv | 24 ++
 rtl/ibex_data_resp_fifo.sv | 60 ++++++
 rtl/ibex_data_resp.sv | 126 ++++++++++++
 tb/tb_ibex_data_resp.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and helpers for the Ibex data-memory responder
package ibex_pkg;

    parameter int DATA_RESP_MAX_OUTSTANDING = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } data_resp_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ibex_data_resp_fifo.sv
// rtl/ibex_data_resp_fifo.sv - in-order response FIFO with registered occupancy count
module ibex_data_resp_fifo #(
    parameter int  Depth   = 2,
    parameter type entry_t = logic,
    parameter int  CntW    = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  entry_t          push_data_i,
    input  logic            pop_i,
    output entry_t          pop_data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    entry_t          store_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = store_q[rd_ptr_q];
    assign full_o     = (count_q == CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/ibex_data_resp.sv
// rtl/ibex_data_resp.sv - word-addressed data-memory responder for the LSU req/gnt/rvalid protocol
module ibex_data_resp
    import ibex_pkg::*;
#(
    parameter int          MemWords       = 1024,
    parameter int          MaxOutstanding = 2,
    parameter int          GntDelay       = 0,
    parameter logic [31:0] ErrBase        = 32'hFFFF_F000,
    parameter logic [31:0] ErrMask        = 32'hFFFF_F000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        resp_stall_i,
    output logic [15:0] err_cnt_o
);

    localparam int AW   = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    if (MaxOutstanding < 1 || MaxOutstanding > DATA_RESP_MAX_OUTSTANDING) begin : g_bad_depth
        $error("ibex_data_resp: MaxOutstanding out of range");
    end
    if (GntDelay < 0 || GntDelay > 15) begin : g_bad_delay
        $error("ibex_data_resp: GntDelay out of range");
    end

    logic [31:0]     mem_q [MemWords];
    logic [3:0]      dly_q;
    logic            rvalid_q, err_q;
    logic [31:0]     rdata_q;
    logic [15:0]     err_cnt_q;

    logic            gnt, fault, deliver;
    logic [AW-1:0]   word_idx;
    data_resp_t      push_entry, head_entry, pop_entry;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            unused_sig;

    assign word_idx = data_addr_i[AW+1:2];
    assign fault    = ((data_addr_i & ErrMask) == ErrBase) ||
                      ({2'b00, data_addr_i[31:2]} >= 32'(MemWords));

    assign gnt = data_req_i && !rst_i && (dly_q == 4'(GntDelay)) &&
                 (fifo_count < CntW'(MaxOutstanding));

    always_comb begin
        push_entry       = '0;
        push_entry.err   = fault;
        if (!fault && !data_we_i) begin
            push_entry.rdata = mem_q[word_idx];
        end
    end

    // An empty FIFO lets a fresh grant bypass storage so load-use latency stays at one cycle.
    assign deliver   = (!fifo_empty || gnt) && !resp_stall_i;
    assign pop_entry = fifo_empty ? push_entry : head_entry;
    assign fifo_pop  = deliver && !fifo_empty;
    assign fifo_push = gnt && !(fifo_empty && deliver);

    ibex_data_resp_fifo #(
        .Depth   (MaxOutstanding),
        .entry_t (data_resp_t),
        .CntW    (CntW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (gnt && data_we_i && !fault) begin
            mem_q[word_idx] <= be_merge(mem_q[word_idx], data_wdata_i, data_be_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q <= '0;
        end else if (!data_req_i || gnt) begin
            dly_q <= '0;
        end else if (dly_q != 4'(GntDelay)) begin
            dly_q <= dly_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rvalid_q <= deliver;
            rdata_q  <= deliver ? pop_entry.rdata : '0;
            err_q    <= deliver && pop_entry.err;
            if (deliver && pop_entry.err && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign err_cnt_o     = err_cnt_q;

    assign unused_sig = ^{data_addr_i[1:0], fifo_full};

endmodule

// File: tb/tb_ibex_data_resp.sv
// tb/tb_ibex_data_resp.sv - scoreboard bench for the data-memory responder
module tb_ibex_data_resp;
    import ibex_pkg::*;

    logic        clk, rst;
    logic        req, gnt, we, rvalid, err, stall;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic [15:0] err_cnt;

    logic        d_req, d_gnt, d_we, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [15:0] d_err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_errcnt = 0;
    data_resp_t sb[$];
    data_resp_t mon_exp;
    logic [31:0] model [1024];

    ibex_data_resp dut (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
        .resp_stall_i(stall), .err_cnt_o(err_cnt)
    );

    ibex_data_resp #(.GntDelay(3)) dut_d (
        .clk_i(clk), .rst_i(rst), .data_req_i(d_req), .data_gnt_o(d_gnt),
        .data_we_i(d_we), .data_be_i(d_be), .data_addr_i(d_addr), .data_wdata_i(d_wdata),
        .data_rvalid_o(d_rvalid), .data_rdata_o(d_rdata), .data_err_o(d_err),
        .resp_stall_i(1'b0), .err_cnt_o(d_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst && rvalid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: rvalid with empty scoreboard rdata=%h err=%b", rdata, err);
            end else begin
                mon_exp = sb.pop_front();
                if (rdata !== mon_exp.rdata || err !== mon_exp.err) begin
                    errors++;
                    $display("FAIL resp_data: got rdata=%h err=%b want rdata=%h err=%b",
                             rdata, err, mon_exp.rdata, mon_exp.err);
                end
                if (mon_exp.err) exp_errcnt++;
                checks++;
                if (err_cnt !== 16'(exp_errcnt)) begin
                    errors++;
                    $display("FAIL err_cnt: got %0d want %0d", err_cnt, exp_errcnt);
                end
            end
        end
    end

    task automatic do_req(input logic r_we, input logic [31:0] r_addr, input logic [31:0] r_wd,
                          input logic [3:0] r_be, output int waited);
        data_resp_t e;
        logic       flt;
        flt = ((r_addr & 32'hFFFF_F000) == 32'hFFFF_F000) || (r_addr[31:2] >= 30'd1024);
        e.err   = flt;
        e.rdata = 32'h0;
        if (!flt && !r_we) e.rdata = model[r_addr[11:2]];
        if (!flt && r_we) begin
            for (int i = 0; i < 4; i++)
                if (r_be[i]) model[r_addr[11:2]][8*i +: 8] = r_wd[8*i +: 8];
        end
        req = 1'b1; we = r_we; addr = r_addr; wdata = r_wd; be = r_be;
        waited = 0;
        @(negedge clk);
        while (!gnt && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        checks++;
        if (gnt !== 1'b1) begin
            errors++;
            $display("FAIL gnt_timeout: addr=%h no grant after %0d cycles", r_addr, waited);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b1; d_req = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (gnt !== 1'b0 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got gnt=%b d_gnt=%b want 0", gnt, d_gnt);
        end
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rvalid=%b rdata=%h err=%b err_cnt=%h want zeros",
                     rvalid, rdata, err, err_cnt);
        end
        req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_store_load;
        int w;
        do_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL store_gnt_wait: got %0d want 0", w); end
        do_req(1'b0, 32'h100, 32'h0, 4'hF, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL load_gnt_wait: got %0d want 0", w); end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL load_latency: got rvalid=%b rdata=%h err=%b want 1 deadbeef 0", rvalid, rdata, err);
        end
        idle(2);
    endtask

    task automatic test_byte_lane;
        int w;
        do_req(1'b1, 32'h100, 32'h000000AA, 4'b0001, w);
        do_req(1'b0, 32'h100, 32'h0, 4'hF, w);
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL byte_lane: got rvalid=%b rdata=%h want 1 deadbeaa", rvalid, rdata);
        end
        idle(2);
    endtask

    task automatic test_fault;
        int w;
        do_req(1'b1, 32'h0, 32'h12345678, 4'hF, w);
        do_req(1'b0, 32'hFFFF_F010, 32'h0, 4'hF, w);
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL fault_region: got rvalid=%b err=%b rdata=%h err_cnt=%0d want 1 1 0 1",
                     rvalid, err, rdata, err_cnt);
        end
        idle(1);
        do_req(1'b1, 32'h1000, 32'h00000BAD, 4'hF, w);
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL fault_range: got rvalid=%b err=%b err_cnt=%0d want 1 1 2", rvalid, err, err_cnt);
        end
        idle(1);
        do_req(1'b0, 32'h0, 32'h0, 4'hF, w);
        @(negedge clk);
        checks++;
        if (rdata !== 32'h12345678 || err !== 1'b0) begin
            errors++;
            $display("FAIL fault_no_write: got rdata=%h err=%b want 12345678 0", rdata, err);
        end
        idle(2);
    endtask

    task automatic test_stall;
        int w;
        data_resp_t e;
        do_req(1'b1, 32'h10, 32'hA0A0A0A0, 4'hF, w);
        do_req(1'b1, 32'h14, 32'hB1B1B1B1, 4'hF, w);
        do_req(1'b1, 32'h18, 32'hC2C2C2C2, 4'hF, w);
        idle(3);
        stall = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 4'hF, w);
        do_req(1'b0, 32'h14, 32'h0, 4'hF, w);
        req = 1'b1; we = 1'b0; addr = 32'h18; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 1'b0 || rvalid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got gnt=%b rvalid=%b want 0 0", i, gnt, rvalid);
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_cycle: got gnt=%b rvalid=%b want 0 0", gnt, rvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (gnt !== 1'b1 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_third_gnt: got gnt=%b rvalid=%b want 1 1", gnt, rvalid);
        end else begin
            e.rdata = 32'hC2C2C2C2; e.err = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== (i < 2)) begin
                errors++;
                $display("FAIL stall_drain: cycle %0d got rvalid=%b want %0d", i, rvalid, (i < 2));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int w;
        int total;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'h10 + 32'(4 * (i % 3)), 32'h0, 4'hF, w);
            total += w;
        end
        checks++;
        if (total != 0) begin
            errors++;
            $display("FAIL b2b_wait: got %0d wait cycles want 0", total);
        end
        idle(3);
    endtask

    task automatic test_reset_mid;
        int w;
        stall = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 4'hF, w);
        do_req(1'b0, 32'h14, 32'h0, 4'hF, w);
        rst = 1'b1;
        idle(2);
        sb.delete();
        exp_errcnt = 0;
        stall = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_rvalid: cycle %0d got rvalid=%b want 0", i, rvalid);
            end
            @(posedge clk); #1;
        end
        do_req(1'b0, 32'h100, 32'h0, 4'hF, w);
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL reset_mid_mem: got rvalid=%b rdata=%h want 1 deadbeaa", rvalid, rdata);
        end
        idle(2);
    endtask

    task automatic test_grant_delay;
        int cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55; d_be = 4'hF;
        cyc = 0;
        @(negedge clk);
        while (!d_gnt && cyc < 10) begin
            cyc++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        checks++;
        if (d_gnt !== 1'b1 || cyc != 3) begin
            errors++;
            $display("FAIL gnt_delay_held: got gnt=%b at cycle %0d want 1 at 3", d_gnt, cyc);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL gnt_delay_resp: got rvalid=%b err=%b rdata=%h want 1 0 0", d_rvalid, d_err, d_rdata);
        end
        idle(2);
        d_req = 1'b1; d_we = 1'b0;
        cyc = 0;
        @(negedge clk);
        if (d_gnt) cyc = 99;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        if (d_gnt) cyc = 99;
        @(posedge clk); #1;
        d_req = 1'b1;
        if (cyc == 0) cyc = 2;
        @(negedge clk);
        while (!d_gnt && cyc < 12) begin
            cyc++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        checks++;
        if (d_gnt !== 1'b1 || cyc != 5) begin
            errors++;
            $display("FAIL gnt_delay_drop: got gnt=%b at cycle %0d want 1 at 5", d_gnt, cyc);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h55) begin
            errors++;
            $display("FAIL gnt_delay_load: got rvalid=%b rdata=%h want 1 00000055", d_rvalid, d_rdata);
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; stall = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_byte_lane();
        test_fault();
        test_stall();
        test_back_to_back();
        test_grant_delay();
        test_reset_mid();
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending responses want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
